mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
// Two-requester sequencer for the data address space: DM 0x0000-0x2fff, timer0 0x7f00-0x7f0b,
// timer1 0x7f10-0x7f1b, interrupt generator (IG) 0x7f20-0x7f23. Round-robin grant between CPU
// M-stage port (req0) and loader port (req1). Decodes the address, checks alignment and range,
// drives DM, timer and IG strobes, and returns raw 32-bit read data; sign/zero extension is downstream.
// PARAMETERS
// DM_LAT   1  DM read latency in cycles, 1..3: dm_rdata valid DM_LAT cycles after dm_en
// PORTS
// clk        in   1   clock, all state on rising edge
// reset      in   1   synchronous, active-high
// reqN       in   1   N=0 CPU, N=1 loader; request, held with its fields until ackN
// weN        in   1   1 = store, 0 = load
// sizeN      in   2   0 byte, 1 half, 2 word, 3 illegal
// addrN      in   32  byte address
// wdataN     in   32  store data, right-justified
// ackN       out  1   one-cycle completion pulse for requester N
// rdata      out  32  registered raw word; valid while ackN=1 on a load
// err        out  1   registered; valid with ackN; 1 = access rejected, no strobe issued
// dm_en      out  1   DM access strobe, one cycle
// dm_we      out  4   DM byte-lane write enables (0 on load)
// dm_addr    out  12  DM word address = addr[13:2]
// dm_wdata   out  32  lane-replicated store data
// dm_rdata   in   32  DM read word
// t0_we      out  1   timer0 write strobe
// t1_we      out  1   timer1 write strobe
// tc_addr    out  2   timer register index = addr[3:2]
// tc_wdata   out  32  timer store data
// t0_rdata   in   32  combinational timer0 read
// t1_rdata   in   32  combinational timer1 read
// ig_we      out  1   IG write pulse
// BEHAVIOUR
// - Reset: state IDLE; last grant = loader, so CPU wins first; all outputs 0.
// - IDLE: if any reqN, pick winner (both pending -> the one not granted last); latch we/size/addr/wdata
//   into the winner's slot; go ISSUE. Losing request waits, and its fields remain stable.
// - Decode in ISSUE, raising err for:
//   - size 3;
//   - word with addr[1:0]!=0;
//   - half with addr[0]!=0;
//   - addr outside all four windows;
//   - timer access with size!=word.
//   If err: no strobe; go RESP.
// - ISSUE strobes, all one cycle:
//   - DM: dm_en=1; dm_we = byte 1<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111 (store),
//     otherwise 0. Store -> RESP; load -> WAIT with cnt=DM_LAT.
//   - dm_wdata / tc_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
//   - Timer: store -> t0_we/t1_we=1; load -> capture t0/t1_rdata at end of ISSUE. Go RESP.
//   - IG: store -> ig_we=1; load returns 0. Go RESP.
// - WAIT: cnt decrements each cycle; capture dm_rdata into rdata in the cycle cnt==1; then go RESP.
// - RESP: ackN=1 for the granted requester only, with rdata/err; update last grant; go IDLE.
// - Latency, req seen in IDLE at cycle 0: store/timer/IG/err ack in cycle 2; DM load ack in cycle 2+DM_LAT.
// - Back-to-back: a req still high in the IDLE cycle after RESP is a new transaction.
// - reqN dropping before ack: protocol violation; transaction completes on latched values.
// - Reset mid-transaction: return to IDLE in the next cycle with no ack. An already-issued write is not
//   undone; no strobe fires in the cycle after reset.
// - Boundaries: 0x2fff (byte) ok; 0x3000 err; 0x7f0c..0x7f0f err; 0x7f23 (byte) ok; 0x7f24 err.
// TESTING
// - CPU sw 0x1234abcd @0x0010 -> dm_en, dm_we=1111, dm_addr=0x004 in cycle 1; ack0 in cycle 2, err=0.
// - CPU lb @0x0013 after that store, DM_LAT=1 -> ack0 in cycle 3, rdata=0x1234abcd, err=0.
// - CPU lh @0x7f04 -> ack0, err=1, no strobe; CPU sw @0x3000 -> err=1; sb @0x2fff -> dm_we=1000.
// - req0/req1 high every cycle, 4 transactions -> grants alternate CPU, loader, CPU, loader.
// - CPU lw @0x7f14 with t1_rdata=0xdeadbeef -> ack0 in cycle 2, rdata=0xdeadbeef.
// - reset during WAIT (DM_LAT=3) -> no ack, IDLE next cycle, a fresh req completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus sequencer: round-robin grant between CPU (port 0) and loader (port 1),
// address decode to DM / timer0 / timer1 / IG windows, one-cycle strobes and registered response.
module mem_bus_arbiter #(
    parameter int DM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        we0,
    input  logic [1:0]  size0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [1:0]  size1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        err,
    output logic        dm_en,
    output logic [3:0]  dm_we,
    output logic [11:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic        t0_we,
    output logic        t1_we,
    output logic [1:0]  tc_addr,
    output logic [31:0] tc_wdata,
    input  logic [31:0] t0_rdata,
    input  logic [31:0] t1_rdata,
    output logic        ig_we
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        hit_dm, hit_t0, hit_t1, hit_ig, hit_tmr, bad;
    logic [3:0]  lane_we;
    logic [31:0] rep_wdata;

    assign rdata = rdata_q;
    assign err   = err_q;

    // Window decode, alignment and size checks on the latched request.
    always_comb begin
        hit_dm  = (addr_q < 32'h0000_3000);
        hit_t0  = (addr_q >= 32'h0000_7f00) && (addr_q <= 32'h0000_7f0b);
        hit_t1  = (addr_q >= 32'h0000_7f10) && (addr_q <= 32'h0000_7f1b);
        hit_ig  = (addr_q >= 32'h0000_7f20) && (addr_q <= 32'h0000_7f23);
        hit_tmr = hit_t0 || hit_t1;
        bad     = (size_q == 2'd3)
               || ((size_q == 2'd2) && (addr_q[1:0] != 2'b00))
               || ((size_q == 2'd1) && addr_q[0])
               || !(hit_dm || hit_tmr || hit_ig)
               || (hit_tmr && (size_q != 2'd2));
        case (size_q)
            2'd0: begin
                lane_we   = 4'b0001 << addr_q[1:0];
                rep_wdata = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                lane_we   = 4'b0011 << addr_q[1:0];
                rep_wdata = {2{wdata_q[15:0]}};
            end
            2'd2: begin
                lane_we   = 4'b1111;
                rep_wdata = wdata_q;
            end
            default: begin
                lane_we   = 4'b0000;
                rep_wdata = 32'h0000_0000;
            end
        endcase
    end

    // Sequencer next-state, latching and strobe generation.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        we_d     = we_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        ack0     = 1'b0;
        ack1     = 1'b0;
        dm_en    = 1'b0;
        dm_we    = 4'b0000;
        dm_addr  = 12'h000;
        dm_wdata = 32'h0000_0000;
        t0_we    = 1'b0;
        t1_we    = 1'b0;
        tc_addr  = 2'b00;
        tc_wdata = 32'h0000_0000;
        ig_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // Contention goes to whichever port was not served last.
                    gnt_d   = (req0 && req1) ? ~last_q : req1;
                    we_d    = gnt_d ? we1    : we0;
                    size_d  = gnt_d ? size1  : size0;
                    addr_d  = gnt_d ? addr1  : addr0;
                    wdata_d = gnt_d ? wdata1 : wdata0;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                err_d   = bad;
                rdata_d = 32'h0000_0000;
                state_d = S_RESP;
                if (bad) begin
                    state_d = S_RESP;
                end else if (hit_dm) begin
                    dm_en    = 1'b1;
                    dm_we    = we_q ? lane_we : 4'b0000;
                    dm_addr  = addr_q[13:2];
                    dm_wdata = rep_wdata;
                    if (we_q) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 2'(DM_LAT);
                    end
                end else if (hit_tmr) begin
                    tc_addr  = addr_q[3:2];
                    tc_wdata = rep_wdata;
                    if (we_q) begin
                        t0_we = hit_t0;
                        t1_we = hit_t1;
                    end else begin
                        rdata_d = hit_t0 ? t0_rdata : t1_rdata;
                    end
                end else begin
                    ig_we = we_q;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    rdata_d = dm_rdata;
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                ack0    = ~gnt_q;
                ack1    = gnt_q;
                last_d  = gnt_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Nothing leaves the block while reset is held, even mid-transaction.
        if (reset) begin
            ack0  = 1'b0;
            ack1  = 1'b0;
            dm_en = 1'b0;
            dm_we = 4'b0000;
            t0_we = 1'b0;
            t1_we = 1'b0;
            ig_we = 1'b0;
        end else begin
            ig_we = ig_we;
        end
    end

    // State and latched-request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: instance A (DM_LAT=1) carries most scenarios,
// instance B (DM_LAT=3) covers long DM latency and reset during WAIT.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        a_reset, b_reset, b_sel;
    logic        req0, we0, req1, we1;
    logic [1:0]  size0, size1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [31:0] t0_rdata, t1_rdata;
    logic        zero1;
    logic [1:0]  zero2;
    logic [31:0] zero32;

    logic        a_req0, b_req0;
    logic        a_ack0, a_ack1, a_err, a_dm_en, a_t0_we, a_t1_we, a_ig_we;
    logic [31:0] a_rdata, a_dm_wdata, a_tc_wdata, a_dm_rdata;
    logic [3:0]  a_dm_we;
    logic [11:0] a_dm_addr;
    logic [1:0]  a_tc_addr;
    logic        b_ack0, b_ack1, b_err, b_dm_en, b_t0_we, b_t1_we, b_ig_we;
    logic [31:0] b_rdata, b_dm_wdata, b_tc_wdata, b_dm_rdata;
    logic [3:0]  b_dm_we;
    logic [11:0] b_dm_addr;
    logic [1:0]  b_tc_addr;

    int n_cmp = 0;
    int n_bad = 0;

    int          obs_lat, obs_dm_cyc, obs_strobes;
    logic [31:0] obs_rdata, obs_dm_wdata, obs_tc_wdata;
    logic        obs_err, obs_wrong_ack, obs_t0, obs_t1, obs_ig;
    logic [3:0]  obs_dm_we;
    logic [11:0] obs_dm_addr;
    logic [1:0]  obs_tc_addr;

    always #5 clk = ~clk;

    assign a_req0 = req0 & ~b_sel;
    assign b_req0 = req0 & b_sel;

    mem_bus_arbiter #(.DM_LAT(1)) dut_a (
        .clk(clk), .reset(a_reset),
        .req0(a_req0), .we0(we0), .size0(size0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .size1(size1), .addr1(addr1), .wdata1(wdata1),
        .ack0(a_ack0), .ack1(a_ack1), .rdata(a_rdata), .err(a_err),
        .dm_en(a_dm_en), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
        .dm_rdata(a_dm_rdata), .t0_we(a_t0_we), .t1_we(a_t1_we), .tc_addr(a_tc_addr),
        .tc_wdata(a_tc_wdata), .t0_rdata(t0_rdata), .t1_rdata(t1_rdata), .ig_we(a_ig_we)
    );

    mem_bus_arbiter #(.DM_LAT(3)) dut_b (
        .clk(clk), .reset(b_reset),
        .req0(b_req0), .we0(we0), .size0(size0), .addr0(addr0), .wdata0(wdata0),
        .req1(zero1), .we1(zero1), .size1(zero2), .addr1(zero32), .wdata1(zero32),
        .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata), .err(b_err),
        .dm_en(b_dm_en), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_rdata(b_dm_rdata), .t0_we(b_t0_we), .t1_we(b_t1_we), .tc_addr(b_tc_addr),
        .tc_wdata(b_tc_wdata), .t0_rdata(t0_rdata), .t1_rdata(t1_rdata), .ig_we(b_ig_we)
    );

    // Data memory models with byte-lane writes and the matching read latency.
    logic [31:0] mem_a [0:4095];
    logic [31:0] mem_b [0:4095];
    logic [31:0] pipe_b [0:2];

    always @(posedge clk) begin
        if (a_dm_en) begin
            for (int l = 0; l < 4; l++)
                if (a_dm_we[l]) mem_a[a_dm_addr][l*8 +: 8] <= a_dm_wdata[l*8 +: 8];
            a_dm_rdata <= mem_a[a_dm_addr];
        end
        if (b_dm_en) begin
            for (int l = 0; l < 4; l++)
                if (b_dm_we[l]) mem_b[b_dm_addr][l*8 +: 8] <= b_dm_wdata[l*8 +: 8];
            pipe_b[0] <= mem_b[b_dm_addr];
        end
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign b_dm_rdata = pipe_b[2];

    wire        s_ack0  = b_sel ? b_ack0  : a_ack0;
    wire        s_ack1  = b_sel ? b_ack1  : a_ack1;
    wire [31:0] s_rdata = b_sel ? b_rdata : a_rdata;
    wire        s_err   = b_sel ? b_err   : a_err;
    wire        s_dm_en = b_sel ? b_dm_en : a_dm_en;

    // One transaction from an IDLE-cycle negedge; records what the bus did until the ack.
    task automatic drive(input bit port, input bit we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        obs_lat = -1; obs_dm_cyc = -1; obs_strobes = 0; obs_wrong_ack = 1'b0;
        obs_t0 = 1'b0; obs_t1 = 1'b0; obs_ig = 1'b0;
        obs_rdata = 32'hx; obs_err = 1'bx;
        if (port) begin
            req1 = 1'b1; we1 = we; size1 = size; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = 1'b1; we0 = we; size0 = size; addr0 = addr; wdata0 = wdata;
        end
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (s_dm_en) begin
                obs_dm_cyc = c; obs_dm_we = a_dm_we; obs_dm_addr = a_dm_addr;
                obs_dm_wdata = a_dm_wdata; obs_strobes++;
            end
            if (a_t0_we | a_t1_we | a_ig_we) begin
                obs_strobes++; obs_tc_addr = a_tc_addr; obs_tc_wdata = a_tc_wdata;
            end
            obs_t0 |= a_t0_we; obs_t1 |= a_t1_we; obs_ig |= a_ig_we;
            if (port ? s_ack0 : s_ack1) obs_wrong_ack = 1'b1;
            if (port ? s_ack1 : s_ack0) begin
                obs_lat = c; obs_rdata = s_rdata; obs_err = s_err;
                break;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        a_reset = 1'b1; b_reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        a_reset = 1'b0; b_reset = 1'b0;
        @(negedge clk);
        n_cmp++; if ({a_ack0, a_ack1} !== 2'b00) begin n_bad++; $display("FAIL reset_ack: got %b want 00", {a_ack0, a_ack1}); end
        n_cmp++; if (a_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", a_rdata); end
        n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", a_err); end
        n_cmp++; if ({a_dm_en, a_dm_we, a_t0_we, a_t1_we, a_ig_we} !== 8'h00) begin
            n_bad++; $display("FAIL reset_strobes: got %b want 0", {a_dm_en, a_dm_we, a_t0_we, a_t1_we, a_ig_we}); end
        n_cmp++; if ({b_ack0, b_dm_en, b_rdata} !== 34'h0) begin n_bad++; $display("FAIL reset_b: got %h want 0", {b_ack0, b_dm_en, b_rdata}); end
    endtask

    task automatic test_dm_store();
        drive(1'b0, 1'b1, 2'd2, 32'h0000_0010, 32'h1234_abcd);
        n_cmp++; if (obs_dm_cyc !== 1) begin n_bad++; $display("FAIL sw_dm_cycle: got %0d want 1", obs_dm_cyc); end
        n_cmp++; if (obs_dm_we !== 4'b1111) begin n_bad++; $display("FAIL sw_dm_we: got %b want 1111", obs_dm_we); end
        n_cmp++; if (obs_dm_addr !== 12'h004) begin n_bad++; $display("FAIL sw_dm_addr: got %h want 004", obs_dm_addr); end
        n_cmp++; if (obs_lat !== 2) begin n_bad++; $display("FAIL sw_ack_cycle: got %0d want 2", obs_lat); end
        n_cmp++; if (obs_err !== 1'b0) begin n_bad++; $display("FAIL sw_err: got %b want 0", obs_err); end
    endtask

    task automatic test_dm_load();
        drive(1'b0, 1'b0, 2'd0, 32'h0000_0013, 32'h0);
        n_cmp++; if (obs_lat !== 3) begin n_bad++; $display("FAIL lb_ack_cycle: got %0d want 3", obs_lat); end
        n_cmp++; if (obs_rdata !== 32'h1234_abcd) begin n_bad++; $display("FAIL lb_rdata: got %h want 1234abcd", obs_rdata); end
        n_cmp++; if (obs_err !== 1'b0) begin n_bad++; $display("FAIL lb_err: got %b want 0", obs_err); end
        n_cmp++; if (obs_dm_we !== 4'b0000) begin n_bad++; $display("FAIL lb_dm_we: got %b want 0000", obs_dm_we); end
    endtask

    task automatic test_errors();
        logic [31:0] ea [0:9];
        logic [1:0]  es [0:9];
        logic        ew [0:9];
        ea = '{32'h7f04, 32'h3000, 32'h3000, 32'h0000, 32'h0002, 32'h0001, 32'h7f0c, 32'h7f0f, 32'h7f24, 32'h7f1c};
        es = '{2'd1,     2'd2,     2'd0,     2'd3,     2'd2,     2'd1,     2'd0,     2'd0,     2'd0,     2'd2};
        ew = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b1};
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, ew[i], es[i], ea[i], 32'hffff_ffff);
            n_cmp++; if (obs_err !== 1'b1) begin n_bad++; $display("FAIL err_flag[%0d]: got %b want 1", i, obs_err); end
            n_cmp++; if (obs_lat !== 2) begin n_bad++; $display("FAIL err_ack_cycle[%0d]: got %0d want 2", i, obs_lat); end
            n_cmp++; if (obs_strobes !== 0) begin n_bad++; $display("FAIL err_strobe[%0d]: got %0d want 0", i, obs_strobes); end
        end
    endtask

    task automatic test_boundaries();
        drive(1'b0, 1'b1, 2'd0, 32'h0000_2fff, 32'h0000_00a5);
        n_cmp++; if ({obs_err, obs_dm_we} !== 5'b0_1000) begin n_bad++; $display("FAIL sb_2fff: got err/we %b want 0/1000", {obs_err, obs_dm_we}); end
        n_cmp++; if (obs_dm_addr !== 12'hbff) begin n_bad++; $display("FAIL sb_2fff_addr: got %h want bff", obs_dm_addr); end
        n_cmp++; if (obs_dm_wdata !== 32'ha5a5_a5a5) begin n_bad++; $display("FAIL sb_wdata: got %h want a5a5a5a5", obs_dm_wdata); end
        drive(1'b0, 1'b1, 2'd1, 32'h0000_0006, 32'h0000_beef);
        n_cmp++; if (obs_dm_we !== 4'b1100) begin n_bad++; $display("FAIL sh_dm_we: got %b want 1100", obs_dm_we); end
        n_cmp++; if (obs_dm_wdata !== 32'hbeef_beef) begin n_bad++; $display("FAIL sh_wdata: got %h want beefbeef", obs_dm_wdata); end
        drive(1'b0, 1'b1, 2'd0, 32'h0000_7f23, 32'h0000_0001);
        n_cmp++; if ({obs_err, obs_ig, obs_lat == 2} !== 3'b011) begin n_bad++; $display("FAIL sb_ig: got err/ig/lat2 %b want 011", {obs_err, obs_ig, obs_lat == 2}); end
        drive(1'b0, 1'b0, 2'd0, 32'h0000_7f23, 32'h0);
        n_cmp++; if ({obs_err, obs_rdata} !== 33'h0) begin n_bad++; $display("FAIL lb_ig: got %h want 0", {obs_err, obs_rdata}); end
    endtask

    task automatic test_timer();
        drive(1'b0, 1'b0, 2'd2, 32'h0000_7f14, 32'h0);
        n_cmp++; if (obs_lat !== 2) begin n_bad++; $display("FAIL lw_t1_cycle: got %0d want 2", obs_lat); end
        n_cmp++; if (obs_rdata !== 32'hdead_beef) begin n_bad++; $display("FAIL lw_t1_rdata: got %h want deadbeef", obs_rdata); end
        drive(1'b0, 1'b0, 2'd2, 32'h0000_7f00, 32'h0);
        n_cmp++; if (obs_rdata !== 32'h0bad_f00d) begin n_bad++; $display("FAIL lw_t0_rdata: got %h want 0badf00d", obs_rdata); end
        drive(1'b0, 1'b1, 2'd2, 32'h0000_7f08, 32'h0000_0055);
        n_cmp++; if ({obs_t0, obs_t1, obs_tc_addr} !== 4'b1010) begin n_bad++; $display("FAIL sw_t0: got t0/t1/idx %b want 1010", {obs_t0, obs_t1, obs_tc_addr}); end
        n_cmp++; if (obs_tc_wdata !== 32'h0000_0055) begin n_bad++; $display("FAIL sw_t0_wdata: got %h want 00000055", obs_tc_wdata); end
    endtask

    task automatic test_loader_load();
        drive(1'b1, 1'b0, 2'd2, 32'h0000_0010, 32'h0);
        n_cmp++; if (obs_lat !== 3) begin n_bad++; $display("FAIL ld_lw_cycle: got %0d want 3", obs_lat); end
        n_cmp++; if (obs_rdata !== 32'h1234_abcd) begin n_bad++; $display("FAIL ld_lw_rdata: got %h want 1234abcd", obs_rdata); end
        n_cmp++; if (obs_wrong_ack !== 1'b0) begin n_bad++; $display("FAIL ld_wrong_ack: got %b want 0", obs_wrong_ack); end
    endtask

    task automatic test_round_robin();
        int    nack;
        int    cyc [0:3];
        logic  who [0:3];
        bit    both;
        nack = 0; both = 1'b0;
        req0 = 1'b1; we0 = 1'b1; size0 = 2'd2; addr0 = 32'h40; wdata0 = 32'h1111_1111;
        req1 = 1'b1; we1 = 1'b1; size1 = 2'd2; addr1 = 32'h44; wdata1 = 32'h2222_2222;
        for (int c = 1; c <= 20 && nack < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (a_ack0 && a_ack1) both = 1'b1;
            if (a_ack0 || a_ack1) begin cyc[nack] = c; who[nack] = a_ack1; nack++; end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (nack !== 4) begin n_bad++; $display("FAIL rr_count: got %0d want 4", nack); end
        n_cmp++; if (both !== 1'b0) begin n_bad++; $display("FAIL rr_double_ack: got %b want 0", both); end
        if (nack == 4) begin
            n_cmp++; if ({who[0], who[1], who[2], who[3]} !== 4'b0101) begin
                n_bad++; $display("FAIL rr_order: got %b want 0101", {who[0], who[1], who[2], who[3]}); end
            n_cmp++; if (cyc[3] !== 11) begin n_bad++; $display("FAIL rr_timing: got %0d want 11", cyc[3]); end
        end
        n_cmp++; if ({mem_a[16], mem_a[17]} !== 64'h1111_1111_2222_2222) begin
            n_bad++; $display("FAIL rr_data: got %h want 1111111122222222", {mem_a[16], mem_a[17]}); end
    endtask

    task automatic test_back_to_back();
        int nack, c2;
        nack = 0; c2 = -1;
        req0 = 1'b1; we0 = 1'b1; size0 = 2'd2; addr0 = 32'h20; wdata0 = 32'h0000_0777;
        for (int c = 1; c <= 12 && nack < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (a_ack0) begin nack++; c2 = c; end
        end
        req0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({nack, c2} !== {32'd2, 32'd5}) begin n_bad++; $display("FAIL b2b: got acks %0d last %0d want 2 at 5", nack, c2); end
    endtask

    task automatic test_reset_wait();
        bit stray;
        b_sel = 1'b1;
        drive(1'b0, 1'b1, 2'd2, 32'h0000_0008, 32'hcafe_f00d);
        n_cmp++; if (obs_lat !== 2) begin n_bad++; $display("FAIL b_sw_cycle: got %0d want 2", obs_lat); end
        drive(1'b0, 1'b0, 2'd2, 32'h0000_0008, 32'h0);
        n_cmp++; if ({obs_lat == 5, obs_rdata} !== {1'b1, 32'hcafe_f00d}) begin
            n_bad++; $display("FAIL b_lw: got lat %0d rdata %h want 5 cafef00d", obs_lat, obs_rdata); end
        req0 = 1'b1; we0 = 1'b0; size0 = 2'd2; addr0 = 32'h8;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        b_reset = 1'b1; req0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        b_reset = 1'b0;
        n_cmp++; if ({b_ack0, b_dm_en} !== 2'b00) begin n_bad++; $display("FAIL rst_next_cycle: got %b want 00", {b_ack0, b_dm_en}); end
        stray = 1'b0;
        repeat (6) begin
            @(posedge clk); @(negedge clk);
            if (b_ack0 || b_dm_en) stray = 1'b1;
        end
        n_cmp++; if (stray !== 1'b0) begin n_bad++; $display("FAIL rst_stray_ack: got %b want 0", stray); end
        drive(1'b0, 1'b0, 2'd2, 32'h0000_0008, 32'h0);
        n_cmp++; if ({obs_lat == 5, obs_rdata} !== {1'b1, 32'hcafe_f00d}) begin
            n_bad++; $display("FAIL rst_fresh: got lat %0d rdata %h want 5 cafef00d", obs_lat, obs_rdata); end
        b_sel = 1'b0;
    endtask

    initial begin
        zero1 = 1'b0; zero2 = 2'd0; zero32 = 32'h0;
        b_sel = 1'b0; a_reset = 1'b1; b_reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0; size0 = 2'd0; addr0 = 32'h0; wdata0 = 32'h0;
        req1 = 1'b0; we1 = 1'b0; size1 = 2'd0; addr1 = 32'h0; wdata1 = 32'h0;
        t0_rdata = 32'h0bad_f00d; t1_rdata = 32'hdead_beef;
        test_reset();
        test_dm_store();
        test_dm_load();
        test_errors();
        test_boundaries();
        test_timer();
        test_loader_load();
        test_round_robin();
        test_back_to_back();
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
